// File: rtl/motor_pkg.sv
// Shared types and helpers for the motor-control encoder front end.
package motor_pkg;

  // Default width of the wheel tick count and its snapshot.
  localparam int unsigned ENC_CNT_W = 24;

  // Width of the per-channel stability counter (FILT_LEN is at most 15).
  localparam int unsigned FILT_CNT_W = 4;

  // Quadrature state is {A, B}.
  typedef logic [1:0] quadState_t;

  localparam quadState_t Q00 = 2'b00;
  localparam quadState_t Q01 = 2'b01;
  localparam quadState_t Q11 = 2'b11;
  localparam quadState_t Q10 = 2'b10;

  // Result of comparing the previous and current quadrature state.
  typedef struct packed {
    logic step;     // exactly one channel changed, legal transition
    logic fwd;      // the legal transition was in the forward order
    logic illegal;  // both channels changed together
  } quadDecode_t;

  // Next quadrature state in the forward (00->01->11->10) or reverse order.
  function automatic quadState_t quadNext(input quadState_t cur, input logic fwd);
    quadState_t nxt;
    case (cur)
      Q00:     nxt = fwd ? Q01 : Q10;
      Q01:     nxt = fwd ? Q11 : Q00;
      Q11:     nxt = fwd ? Q10 : Q01;
      default: nxt = fwd ? Q00 : Q11;
    endcase
    return nxt;
  endfunction

  // Classify a transition from prevState to currState.
  function automatic quadDecode_t quadDecode(input quadState_t prevState,
                                             input quadState_t currState);
    quadDecode_t res;
    logic        isFwd;
    logic        isRev;
    isFwd       = (currState == quadNext(prevState, 1'b1));
    isRev       = (currState == quadNext(prevState, 1'b0));
    res.step    = isFwd | isRev;
    res.fwd     = isFwd;
    res.illegal = (currState != prevState) & ~(isFwd | isRev);
    return res;
  endfunction

endpackage

// File: rtl/enc_glitch_filter.sv
// Per-channel encoder input conditioning: 2-FF synchroniser followed by a
// stability filter that only accepts a new level after FILT_LEN samples.
module enc_glitch_filter
  import motor_pkg::*;
#(
  parameter int unsigned FILT_LEN = 3
) (
  input  logic i_Clock,
  input  logic i_Rst,
  input  logic i_Pin,
  output logic o_Filt
);

  logic                  syncMeta;
  logic                  syncOut;
  logic [FILT_CNT_W-1:0] stableCnt;
  logic                  cntLast;

  // Counter value on which the next differing sample completes the window.
  assign cntLast = (stableCnt == FILT_CNT_W'(FILT_LEN - 1));

  // Two-stage synchroniser for the asynchronous pin.
  always_ff @(posedge i_Clock) begin
    if (i_Rst) begin
      syncMeta <= 1'b0;
      syncOut  <= 1'b0;
    end else begin
      syncMeta <= i_Pin;
      syncOut  <= syncMeta;
    end
  end

  // Count consecutive samples that disagree with the filtered level; adopt
  // the new level when the count would reach FILT_LEN.
  always_ff @(posedge i_Clock) begin
    if (i_Rst) begin
      stableCnt <= '0;
      o_Filt    <= 1'b0;
    end else if (syncOut == o_Filt) begin
      stableCnt <= '0;
    end else if (cntLast) begin
      stableCnt <= '0;
      o_Filt    <= syncOut;
    end else begin
      stableCnt <= stableCnt + FILT_CNT_W'(1);
    end
  end

endmodule

// File: rtl/quad_enc_counter.sv
// Quadrature encoder front end for one drive wheel: filtered x4 decode,
// saturating tick count, direction, zero/snapshot handshake and a sticky
// illegal-transition flag.
module quad_enc_counter
  import motor_pkg::*;
#(
  parameter int unsigned FILT_LEN   = 3,
  parameter int unsigned CNT_W      = ENC_CNT_W,
  parameter bit          INVERT_DIR = 1'b0
) (
  input  logic             i_Clock,
  input  logic             i_Rst,
  input  logic             i_EncA,
  input  logic             i_EncB,
  input  logic             i_ZeroEnc,
  output logic [CNT_W-1:0] o_EncCnt,
  output logic             o_WhlDir,
  output logic [CNT_W-1:0] o_SnapCnt,
  output logic             o_SnapValid,
  output logic             o_Tick,
  output logic             o_IllegalErr
);

  logic        aFilt;
  logic        bFilt;
  quadState_t  currState;
  quadState_t  prevState;
  quadDecode_t dec;
  logic        cntFull;

  enc_glitch_filter #(.FILT_LEN(FILT_LEN)) uFiltA (
    .i_Clock (i_Clock),
    .i_Rst   (i_Rst),
    .i_Pin   (i_EncA),
    .o_Filt  (aFilt)
  );

  enc_glitch_filter #(.FILT_LEN(FILT_LEN)) uFiltB (
    .i_Clock (i_Clock),
    .i_Rst   (i_Rst),
    .i_Pin   (i_EncB),
    .o_Filt  (bFilt)
  );

  // Classify the filtered state against the one seen on the previous cycle.
  always_comb begin
    currState = {aFilt, bFilt};
    dec       = quadDecode(prevState, currState);
    cntFull   = &o_EncCnt;
  end

  // Previous-state register; after reset the next step is judged against 00.
  always_ff @(posedge i_Clock) begin
    if (i_Rst) begin
      prevState <= Q00;
    end else begin
      prevState <= currState;
    end
  end

  // Tick count with saturation; a zero request snapshots and clears it but
  // keeps a coincident step so no transition is lost.
  always_ff @(posedge i_Clock) begin
    if (i_Rst) begin
      o_EncCnt    <= '0;
      o_SnapCnt   <= '0;
      o_SnapValid <= 1'b0;
      o_Tick      <= 1'b0;
    end else begin
      o_Tick      <= dec.step;
      o_SnapValid <= i_ZeroEnc;
      if (i_ZeroEnc) begin
        o_SnapCnt <= o_EncCnt;
        o_EncCnt  <= CNT_W'(dec.step);
      end else if (dec.step && !cntFull) begin
        o_EncCnt <= o_EncCnt + CNT_W'(1);
      end
    end
  end

  // Direction of the most recent legal step, optionally mirrored.
  always_ff @(posedge i_Clock) begin
    if (i_Rst) begin
      o_WhlDir <= 1'b1;
    end else if (dec.step) begin
      o_WhlDir <= dec.fwd ^ INVERT_DIR;
    end
  end

  // Sticky flag for a double-channel change; only reset clears it.
  always_ff @(posedge i_Clock) begin
    if (i_Rst) begin
      o_IllegalErr <= 1'b0;
    end else if (dec.illegal) begin
      o_IllegalErr <= 1'b1;
    end
  end

endmodule
